// File: rtl/apb_cmd_master_if.sv
// ----------------------------------------------------------------------------
// apb_cmd_master_if
// Bundles the command/response handshake of apb_cmd_master together with its
// APB segment into a single interface.
//   master modport : the APB master's view (commands in, responses out,
//                    APB request signals out, slave return signals in)
//   slave  modport : the opposite view, used by the fabric/peripheral side
// Signals:
//   cmd_valid/cmd_ready/cmd_addr/cmd_write/cmd_wdata : command port
//   rsp_valid/rsp_rdata/rsp_err                      : one-cycle response
//   psel/penable/paddr/pwrite/pwdata                 : APB request
//   prdata/pready/pslverr                            : per-slave APB return,
//                                                      slave i data at
//                                                      prdata[i*DATA_W +: DATA_W]
// ----------------------------------------------------------------------------
interface apb_cmd_master_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [ADDR_W-1:0]            cmd_addr;
    logic                         cmd_write;
    logic [DATA_W-1:0]            cmd_wdata;

    logic                         rsp_valid;
    logic [DATA_W-1:0]            rsp_rdata;
    logic                         rsp_err;

    logic [NUM_SLAVES-1:0]        psel;
    logic                         penable;
    logic [ADDR_W-1:0]            paddr;
    logic                         pwrite;
    logic [DATA_W-1:0]            pwdata;
    logic [NUM_SLAVES*DATA_W-1:0] prdata;
    logic [NUM_SLAVES-1:0]        pready;
    logic [NUM_SLAVES-1:0]        pslverr;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, paddr, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, paddr, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_cmd_master.sv
// ----------------------------------------------------------------------------
// apb_cmd_master
// APB master that converts a valid/ready command stream into APB SETUP/ACCESS
// transfers towards NUM_SLAVES slaves. The target slave is decoded from
// cmd_addr[SEL_LSB +: SEL_W]; an index >= NUM_SLAVES completes immediately
// with an error response and never touches the bus. Every transfer produces
// exactly one rsp_valid strobe carrying read data and error status.
//
// Optional feature (compile-time macro APB_TIMEOUT_EN):
//   defined   : an ACCESS phase waiting TIMEOUT cycles without pready is
//               aborted and answered with rsp_err=1.
//   undefined : ACCESS waits for pready indefinitely.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : apb_cmd_master_if.master (command, response and APB signals)
// All interface outputs are registered except cmd_ready, which is high
// exactly while the FSM is IDLE.
// ----------------------------------------------------------------------------
module apb_cmd_master #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_LSB    = 12,
    parameter int SEL_W      = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             rst,
    apb_cmd_master_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Slave count widened by one bit so the index compare cannot overflow.
    localparam logic [SEL_W:0] NUM_SLAVES_CMP = (SEL_W+1)'(NUM_SLAVES);

    state_t                r_state;
    state_t                w_state_nxt;

    logic [NUM_SLAVES-1:0] r_psel;
    logic [NUM_SLAVES-1:0] w_psel_nxt;
    logic                  r_penable;
    logic                  w_penable_nxt;
    logic [ADDR_W-1:0]     r_paddr;
    logic [ADDR_W-1:0]     w_paddr_nxt;
    logic                  r_pwrite;
    logic                  w_pwrite_nxt;
    logic [DATA_W-1:0]     r_pwdata;
    logic [DATA_W-1:0]     w_pwdata_nxt;
    logic                  r_rsp_valid;
    logic                  w_rsp_valid_nxt;
    logic                  r_rsp_err;
    logic                  w_rsp_err_nxt;
    logic [DATA_W-1:0]     r_rsp_rdata;
    logic [DATA_W-1:0]     w_rsp_rdata_nxt;

    logic                  w_accept;
    logic [SEL_W-1:0]      w_idx;
    logic                  w_dec_ok;
    logic [NUM_SLAVES-1:0] w_psel_dec;
    logic                  w_pready_sel;
    logic                  w_pslverr_sel;
    logic [DATA_W-1:0]     w_prdata_sel;
    logic                  w_timeout;

    assign w_accept = bus.cmd_valid & (r_state == ST_IDLE);
    assign w_idx    = bus.cmd_addr[SEL_LSB +: SEL_W];
    assign w_dec_ok = ({1'b0, w_idx} < NUM_SLAVES_CMP);

    // One-hot select for the slave addressed by the incoming command.
    always_comb begin
        w_psel_dec = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_psel_dec[i] = (w_idx == SEL_W'(i));
        end
    end

    // Return signals are masked by the registered one-hot psel, so whatever
    // a non-selected slave drives (including X) reads as zero here.
    assign w_pready_sel  = |(bus.pready  & r_psel);
    assign w_pslverr_sel = |(bus.pslverr & r_psel);

    // AND-OR read-data mux over the selected slave's slice.
    always_comb begin
        w_prdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_prdata_sel = w_prdata_sel | (bus.prdata[i*DATA_W +: DATA_W] & {DATA_W{r_psel[i]}});
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_wait_cnt;

    // The last permitted wait cycle is the one where TIMEOUT-1 waits have
    // already been counted and pready is still low.
    assign w_timeout = (r_state == ST_ACCESS) && !w_pready_sel &&
                       (r_wait_cnt == CNT_W'(TIMEOUT - 1));

    // Wait-state counter: cleared while entering ACCESS, +1 per wait cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_ACCESS) && !w_pready_sel) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; a decode error never leaves IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_dec_ok) begin
                    w_state_nxt = ST_SETUP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_pready_sel || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM output logic: next values of the registered bus and response
    // signals. paddr/pwrite/pwdata keep their last value outside accept.
    always_comb begin
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_paddr_nxt     = r_paddr;
        w_pwrite_nxt    = r_pwrite;
        w_pwdata_nxt    = r_pwdata;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_paddr_nxt  = bus.cmd_addr;
                    w_pwrite_nxt = bus.cmd_write;
                    w_pwdata_nxt = bus.cmd_wdata;
                    if (w_dec_ok) begin
                        w_psel_nxt    = w_psel_dec;
                        w_penable_nxt = 1'b0;
                    end else begin
                        w_psel_nxt      = '0;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                    end
                end else begin
                    w_psel_nxt    = '0;
                    w_penable_nxt = 1'b0;
                end
            end
            ST_SETUP: begin
                w_penable_nxt = 1'b1;
            end
            ST_ACCESS: begin
                if (w_pready_sel) begin
                    w_psel_nxt      = '0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = w_pslverr_sel;
                    w_rsp_rdata_nxt = r_pwrite ? {DATA_W{1'b0}} : w_prdata_sel;
                end else if (w_timeout) begin
                    w_psel_nxt      = '0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                end else begin
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_psel_nxt    = '0;
                w_penable_nxt = 1'b0;
            end
        endcase
    end

    // Output registers for APB request and response signals.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.paddr     = r_paddr;
    assign bus.pwrite    = r_pwrite;
    assign bus.pwdata    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule
